// File: rtl/canvas_write_arbiter_if.sv
// ============================================================================
// Module   : canvas_write_arbiter_if
// Brief    : Tool-side pixel streams and canvas write bus of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface canvas_write_arbiter_if #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_LAYERS  = 4,
  parameter int COLOR_WIDTH = 3
);
  localparam int c_XW = $clog2(WIDTH);
  localparam int c_YW = $clog2(HEIGHT);

  logic [2:0]             layer;
  logic [NUM_LAYERS-1:0]  layer_visible;
  logic                   clear_req;
  logic                   fh_valid;
  logic [c_XW-1:0]        fh_x;
  logic [c_YW-1:0]        fh_y;
  logic [COLOR_WIDTH-1:0] fh_color;
  logic                   sh_valid;
  logic                   sh_ready;
  logic [c_XW-1:0]        sh_x;
  logic [c_YW-1:0]        sh_y;
  logic [COLOR_WIDTH-1:0] sh_color;
  logic [NUM_LAYERS-1:0]  canvas_we;
  logic [c_XW-1:0]        tool_x;
  logic [c_YW-1:0]        tool_y;
  logic [COLOR_WIDTH-1:0] tool_color;
  logic                   busy;
  logic                   clear_done;

  modport slave (
    input  layer, layer_visible, clear_req,
    input  fh_valid, fh_x, fh_y, fh_color,
    input  sh_valid, sh_x, sh_y, sh_color,
    output sh_ready, canvas_we, tool_x, tool_y, tool_color, busy, clear_done
  );

  modport master (
    output layer, layer_visible, clear_req,
    output fh_valid, fh_x, fh_y, fh_color,
    output sh_valid, sh_x, sh_y, sh_color,
    input  sh_ready, canvas_we, tool_x, tool_y, tool_color, busy, clear_done
  );
endinterface

`default_nettype wire

// File: rtl/canvas_write_arbiter.sv
// ============================================================================
// Module   : canvas_write_arbiter
// Brief    : Shares the single canvas write path between freehand, shape and
//            layer-clear writers; one registered write per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module canvas_write_arbiter #(
  parameter int                     WIDTH       = 640,
  parameter int                     HEIGHT      = 480,
  parameter int                     NUM_LAYERS  = 4,
  parameter int                     COLOR_WIDTH = 3,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  canvas_write_arbiter_if.slave bus
);
  localparam int c_XW = $clog2(WIDTH);
  localparam int c_YW = $clog2(HEIGHT);

  typedef enum logic [0:0] {SERVE = 1'b0, CLEAR = 1'b1} state_t;
  typedef enum logic [0:0] {GR_FH = 1'b0, GR_SH = 1'b1} grant_t;

  state_t                 r_state, w_next_state;
  grant_t                 r_last_grant, w_last_grant;
  logic [2:0]             r_target, w_target;
  logic [c_XW-1:0]        r_cx, w_cx;
  logic [c_YW-1:0]        r_cy, w_cy;
  logic                   r_sweep_end, w_sweep_end;
  logic [NUM_LAYERS-1:0]  r_canvas_we, w_canvas_we;
  logic [c_XW-1:0]        r_tool_x, w_tool_x;
  logic [c_YW-1:0]        r_tool_y, w_tool_y;
  logic [COLOR_WIDTH-1:0] r_tool_color, w_tool_color;
  logic                   r_busy, w_busy;
  logic                   r_clear_done, w_clear_done;
  logic                   w_sh_ready;

  logic [NUM_LAYERS-1:0]  w_sel, w_tsel;
  logic                   w_fh_ok, w_sh_ok;
  logic [c_XW-1:0]        w_ax, w_adv_x;
  logic [c_YW-1:0]        w_ay, w_adv_y;
  logic                   w_adv_last;

  // One-hot decode of the selected layer and of the latched clear target
  always_comb begin
    w_sel  = '0;
    w_tsel = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (32'(bus.layer) == i + 1) w_sel[i]  = 1'b1;
      if (32'(r_target)  == i + 1) w_tsel[i] = 1'b1;
    end
  end

  assign w_fh_ok = (|(w_sel & bus.layer_visible)) &&
                   (32'(bus.fh_x) < WIDTH) && (32'(bus.fh_y) < HEIGHT);
  assign w_sh_ok = (|(w_sel & bus.layer_visible)) &&
                   (32'(bus.sh_x) < WIDTH) && (32'(bus.sh_y) < HEIGHT);

  // Raster successor of the coordinate being written this cycle
  always_comb begin
    w_ax       = (r_state == CLEAR) ? r_cx : '0;
    w_ay       = (r_state == CLEAR) ? r_cy : '0;
    w_adv_last = (32'(w_ax) == WIDTH - 1) && (32'(w_ay) == HEIGHT - 1);
    w_adv_x    = w_ax;
    w_adv_y    = w_ay;
    if (32'(w_ax) == WIDTH - 1) begin
      w_adv_x = '0;
      if (!w_adv_last) w_adv_y = w_ay + c_YW'(1);
    end else begin
      w_adv_x = w_ax + c_XW'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_last_grant = r_last_grant;
    w_target     = r_target;
    w_cx         = r_cx;
    w_cy         = r_cy;
    w_sweep_end  = r_sweep_end;
    w_canvas_we  = '0;
    w_tool_x     = r_tool_x;
    w_tool_y     = r_tool_y;
    w_tool_color = r_tool_color;
    w_busy       = 1'b0;
    w_clear_done = 1'b0;
    w_sh_ready   = 1'b0;
    case (r_state)
      SERVE: begin
        w_sh_ready = !bus.clear_req && (!bus.fh_valid || r_last_grant == GR_FH);
        if (bus.clear_req) begin
          w_target = bus.layer;
          if (|w_sel) begin
            // The (0,0) write is issued in the request cycle itself
            w_next_state = CLEAR;
            w_busy       = 1'b1;
            w_canvas_we  = w_sel;
            w_tool_x     = '0;
            w_tool_y     = '0;
            w_tool_color = COLOR_NONE;
            w_cx         = w_adv_x;
            w_cy         = w_adv_y;
            w_sweep_end  = w_adv_last;
          end else begin
            w_clear_done = 1'b1;
          end
        end else if (bus.fh_valid && !(bus.sh_valid && r_last_grant == GR_FH)) begin
          w_last_grant = GR_FH;
          w_canvas_we  = w_fh_ok ? w_sel : '0;
          w_tool_x     = bus.fh_x;
          w_tool_y     = bus.fh_y;
          w_tool_color = bus.fh_color;
        end else if (bus.sh_valid) begin
          w_last_grant = GR_SH;
          w_canvas_we  = w_sh_ok ? w_sel : '0;
          w_tool_x     = bus.sh_x;
          w_tool_y     = bus.sh_y;
          w_tool_color = bus.sh_color;
        end
      end
      CLEAR: begin
        if (r_sweep_end) begin
          w_next_state = SERVE;
          w_clear_done = 1'b1;
          w_sweep_end  = 1'b0;
        end else begin
          w_busy       = 1'b1;
          w_canvas_we  = w_tsel;
          w_tool_x     = r_cx;
          w_tool_y     = r_cy;
          w_tool_color = COLOR_NONE;
          w_cx         = w_adv_x;
          w_cy         = w_adv_y;
          w_sweep_end  = w_adv_last;
        end
      end
      default: w_next_state = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SERVE;
      r_last_grant <= GR_SH;
      r_target     <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_sweep_end  <= 1'b0;
      r_canvas_we  <= '0;
      r_tool_x     <= '0;
      r_tool_y     <= '0;
      r_tool_color <= COLOR_NONE;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_last_grant;
      r_target     <= w_target;
      r_cx         <= w_cx;
      r_cy         <= w_cy;
      r_sweep_end  <= w_sweep_end;
      r_canvas_we  <= w_canvas_we;
      r_tool_x     <= w_tool_x;
      r_tool_y     <= w_tool_y;
      r_tool_color <= w_tool_color;
      r_busy       <= w_busy;
      r_clear_done <= w_clear_done;
    end
  end

  assign bus.sh_ready   = w_sh_ready && !reset;
  assign bus.canvas_we  = r_canvas_we;
  assign bus.tool_x     = r_tool_x;
  assign bus.tool_y     = r_tool_y;
  assign bus.tool_color = r_tool_color;
  assign bus.busy       = r_busy;
  assign bus.clear_done = r_clear_done;

endmodule

`default_nettype wire

// File: tb/tb_canvas_write_arbiter.sv
// ============================================================================
// Module   : tb_canvas_write_arbiter
// Brief    : Directed and randomized bench for canvas_write_arbiter with a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_canvas_write_arbiter;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NL = 4;
  localparam int CW = 3;
  localparam logic [CW-1:0] CNONE = 3'd0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  canvas_write_arbiter_if #(.WIDTH(W), .HEIGHT(H), .NUM_LAYERS(NL), .COLOR_WIDTH(CW)) bus();

  canvas_write_arbiter #(
    .WIDTH(W), .HEIGHT(H), .NUM_LAYERS(NL), .COLOR_WIDTH(CW), .COLOR_NONE(CNONE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: last winner (0=freehand, 1=shape), clear progress k
  // (-1 when idle, W*H when only the done pulse remains) and clear target.
  int m_last = 1;
  int m_k = -1;
  int m_target = 0;
  logic [NL-1:0] e_we;
  logic [2:0]    e_x, e_y, e_color;
  logic          e_busy, e_done, e_sh_ready, obs_sh_ready;

  task automatic set_idle();
    bus.clear_req = 1'b0;
    bus.fh_valid = 1'b0; bus.fh_x = '0; bus.fh_y = '0; bus.fh_color = '0;
    bus.sh_valid = 1'b0; bus.sh_x = '0; bus.sh_y = '0; bus.sh_color = '0;
  endtask

  task automatic model_eval();
    int lay, winner, px, py, pc;
    e_we = '0; e_busy = 1'b0; e_done = 1'b0; e_sh_ready = 1'b0;
    lay = int'(bus.layer);
    if (reset) begin
      m_last = 1; m_k = -1;
    end else if (m_k >= 0) begin
      if (m_k < W * H) begin
        e_we[m_target-1] = 1'b1;
        px = m_k % W; py = m_k / W;
        e_x = px[2:0]; e_y = py[2:0]; e_color = CNONE;
        e_busy = 1'b1;
        m_k++;
      end else begin
        e_done = 1'b1;
        m_k = -1;
      end
    end else begin
      e_sh_ready = !bus.clear_req && (!bus.fh_valid || m_last == 0);
      if (bus.clear_req) begin
        if (lay >= 1 && lay <= NL) begin
          m_target = lay;
          e_we[lay-1] = 1'b1;
          e_x = 3'd0; e_y = 3'd0; e_color = CNONE;
          e_busy = 1'b1;
          m_k = 1;
        end else begin
          e_done = 1'b1;
        end
      end else begin
        winner = -1;
        if (bus.fh_valid && bus.sh_valid) winner = (m_last == 1) ? 0 : 1;
        else if (bus.fh_valid) winner = 0;
        else if (bus.sh_valid) winner = 1;
        if (winner >= 0) begin
          m_last = winner;
          px = (winner == 0) ? int'(bus.fh_x) : int'(bus.sh_x);
          py = (winner == 0) ? int'(bus.fh_y) : int'(bus.sh_y);
          pc = (winner == 0) ? int'(bus.fh_color) : int'(bus.sh_color);
          e_x = px[2:0]; e_y = py[2:0]; e_color = pc[2:0];
          if (lay >= 1 && lay <= NL && px < W && py < H && bus.layer_visible[lay-1])
            e_we[lay-1] = 1'b1;
        end
      end
    end
  endtask

  // Apply the inputs already driven for one clock; sample outputs 1ns after the edge
  task automatic tick();
    #1;
    obs_sh_ready = bus.sh_ready;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    bus.layer = 3'd1; bus.layer_visible = 4'b1111;
    bus.sh_valid = 1'b1;
    tick(); tick();
    n_checks++; if (obs_sh_ready !== 1'b0) begin n_errors++; $display("FAIL reset_sh_ready: got %b expected 0", obs_sh_ready); end
    n_checks++; if (bus.canvas_we !== 4'b0000) begin n_errors++; $display("FAIL reset_we: got %b expected 0000", bus.canvas_we); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.clear_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", bus.clear_done); end
    n_checks++; if (bus.tool_x !== 3'd0 || bus.tool_y !== 3'd0) begin n_errors++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", bus.tool_x, bus.tool_y); end
    n_checks++; if (bus.tool_color !== CNONE) begin n_errors++; $display("FAIL reset_color: got %0d expected %0d", bus.tool_color, CNONE); end
    reset = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_freehand();
    bus.layer = 3'd1; bus.layer_visible = 4'b0001;
    bus.fh_valid = 1'b1; bus.fh_x = 3'd3; bus.fh_y = 3'd5; bus.fh_color = 3'd2;
    tick();
    n_checks++; if (bus.canvas_we !== 4'b0001) begin n_errors++; $display("FAIL fh_we: got %b expected 0001", bus.canvas_we); end
    n_checks++; if (bus.tool_x !== 3'd3 || bus.tool_y !== 3'd5) begin n_errors++; $display("FAIL fh_xy: got (%0d,%0d) expected (3,5)", bus.tool_x, bus.tool_y); end
    n_checks++; if (bus.tool_color !== 3'd2) begin n_errors++; $display("FAIL fh_color: got %0d expected 2", bus.tool_color); end
    bus.layer_visible = 4'b0000;
    tick();
    n_checks++; if (bus.canvas_we !== 4'b0000) begin n_errors++; $display("FAIL fh_hidden_we: got %b expected 0000", bus.canvas_we); end
    set_idle();
    tick();
    n_checks++; if (bus.canvas_we !== 4'b0000) begin n_errors++; $display("FAIL fh_single_cycle_we: got %b expected 0000", bus.canvas_we); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; set_idle(); tick(); reset = 1'b0;
    bus.layer = 3'd2; bus.layer_visible = 4'b1111;
    bus.fh_valid = 1'b1; bus.fh_x = 3'd1; bus.fh_y = 3'd1; bus.fh_color = 3'd1;
    bus.sh_valid = 1'b1; bus.sh_x = 3'd6; bus.sh_y = 3'd6; bus.sh_color = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (obs_sh_ready !== (i % 2 == 1)) begin n_errors++; $display("FAIL rr_sh_ready[%0d]: got %b expected %b", i, obs_sh_ready, (i % 2 == 1)); end
      n_checks++; if (bus.canvas_we !== 4'b0010) begin n_errors++; $display("FAIL rr_we[%0d]: got %b expected 0010", i, bus.canvas_we); end
      n_checks++; if (bus.tool_x !== ((i % 2 == 1) ? 3'd6 : 3'd1)) begin n_errors++; $display("FAIL rr_src[%0d]: got x=%0d expected %0d", i, bus.tool_x, (i % 2 == 1) ? 6 : 1); end
    end
    set_idle();
    tick();
  endtask

  task automatic test_clear();
    int nwr = 0, nbusy = 0, last_wr = -10, done_cyc = -1;
    bus.layer = 3'd3; bus.layer_visible = 4'b0100;
    for (int cyc = 0; cyc < 120 && done_cyc < 0; cyc++) begin
      bus.clear_req = (cyc == 0 || cyc == 30);
      if (cyc == 5) bus.layer = 3'd1;
      bus.fh_valid = (cyc >= 10 && cyc <= 20);
      bus.sh_valid = (cyc >= 10 && cyc <= 20);
      bus.fh_x = 3'd2; bus.fh_y = 3'd2; bus.fh_color = 3'd3;
      bus.sh_x = 3'd4; bus.sh_y = 3'd4; bus.sh_color = 3'd4;
      tick();
      n_checks++; if (obs_sh_ready !== e_sh_ready) begin n_errors++; $display("FAIL clr_sh_ready c%0d: got %b expected %b", cyc, obs_sh_ready, e_sh_ready); end
      n_checks++; if (bus.canvas_we !== e_we) begin n_errors++; $display("FAIL clr_we c%0d: got %b expected %b", cyc, bus.canvas_we, e_we); end
      n_checks++; if (bus.busy !== e_busy || bus.clear_done !== e_done) begin n_errors++; $display("FAIL clr_busy_done c%0d: got %b/%b expected %b/%b", cyc, bus.busy, bus.clear_done, e_busy, e_done); end
      if (bus.canvas_we === 4'b0100) begin
        n_checks++;
        if (int'(bus.tool_x) != nwr % W || int'(bus.tool_y) != nwr / W || bus.tool_color !== CNONE) begin
          n_errors++; $display("FAIL clr_pixel %0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)", nwr, bus.tool_x, bus.tool_y, bus.tool_color, nwr % W, nwr / W, CNONE);
        end
        nwr++; last_wr = cyc;
      end
      if (bus.busy === 1'b1) nbusy++;
      if (bus.clear_done === 1'b1) done_cyc = cyc;
    end
    n_checks++; if (nwr != W * H) begin n_errors++; $display("FAIL clr_write_count: got %0d expected %0d", nwr, W * H); end
    n_checks++; if (nbusy != W * H) begin n_errors++; $display("FAIL clr_busy_cycles: got %0d expected %0d", nbusy, W * H); end
    n_checks++; if (done_cyc != last_wr + 1) begin n_errors++; $display("FAIL clr_done_timing: got cycle %0d expected %0d", done_cyc, last_wr + 1); end
    set_idle();
    tick();
  endtask

  task automatic test_invalid_clear();
    logic [2:0] bad [2];
    bad[0] = 3'd0; bad[1] = 3'd5;
    bus.layer_visible = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      bus.layer = bad[i]; bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      n_checks++; if (bus.canvas_we !== 4'b0000 || bus.busy !== 1'b0 || bus.clear_done !== 1'b1) begin n_errors++; $display("FAIL badclr_pulse L%0d: got we=%b busy=%b done=%b expected 0000/0/1", bad[i], bus.canvas_we, bus.busy, bus.clear_done); end
      tick();
      n_checks++; if (bus.clear_done !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL badclr_after L%0d: got busy=%b done=%b expected 0/0", bad[i], bus.busy, bus.clear_done); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int nwr = 0, ndone = 0;
    bus.layer = 3'd2; bus.layer_visible = 4'b1111; bus.clear_req = 1'b1;
    for (int cyc = 0; cyc < 100 && nwr < 20; cyc++) begin
      tick();
      bus.clear_req = 1'b0;
      if (bus.canvas_we !== 4'b0000) nwr++;
    end
    n_checks++; if (nwr != 20) begin n_errors++; $display("FAIL rstclr_reach: got %0d writes expected 20", nwr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.canvas_we !== 4'b0000 || bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin n_errors++; $display("FAIL rstclr_abort: got we=%b busy=%b done=%b expected 0000/0/0", bus.canvas_we, bus.busy, bus.clear_done); end
    for (int cyc = 0; cyc < 70; cyc++) begin
      tick();
      if (bus.clear_done === 1'b1 || bus.canvas_we !== 4'b0000) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_errors++; $display("FAIL rstclr_quiet: got %0d active cycles expected 0", ndone); end
    bus.fh_valid = 1'b1; bus.fh_x = 3'd2; bus.fh_y = 3'd7; bus.fh_color = 3'd6;
    tick();
    n_checks++; if (bus.canvas_we !== 4'b0010 || bus.tool_x !== 3'd2 || bus.tool_y !== 3'd7 || bus.tool_color !== 3'd6) begin n_errors++; $display("FAIL rstclr_fh: got we=%b (%0d,%0d,c%0d) expected 0010 (2,7,c6)", bus.canvas_we, bus.tool_x, bus.tool_y, bus.tool_color); end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      bus.clear_req = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) bus.layer = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) bus.layer_visible = 4'($urandom);
      bus.fh_valid = 1'($urandom); bus.fh_x = 3'($urandom); bus.fh_y = 3'($urandom); bus.fh_color = 3'($urandom);
      bus.sh_valid = 1'($urandom); bus.sh_x = 3'($urandom); bus.sh_y = 3'($urandom); bus.sh_color = 3'($urandom);
      tick();
      n_checks++; if (obs_sh_ready !== e_sh_ready) begin n_errors++; $display("FAIL rnd_sh_ready c%0d: got %b expected %b", cyc, obs_sh_ready, e_sh_ready); end
      n_checks++; if (bus.canvas_we !== e_we) begin n_errors++; $display("FAIL rnd_we c%0d: got %b expected %b", cyc, bus.canvas_we, e_we); end
      n_checks++; if (bus.busy !== e_busy || bus.clear_done !== e_done) begin n_errors++; $display("FAIL rnd_busy_done c%0d: got %b/%b expected %b/%b", cyc, bus.busy, bus.clear_done, e_busy, e_done); end
      if (e_we != '0) begin
        n_checks++;
        if (bus.tool_x !== e_x || bus.tool_y !== e_y || bus.tool_color !== e_color) begin
          n_errors++; $display("FAIL rnd_pixel c%0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)", cyc, bus.tool_x, bus.tool_y, bus.tool_color, e_x, e_y, e_color);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    bus.layer = 3'd0;
    bus.layer_visible = 4'b0000;
    test_reset();
    test_freehand();
    test_round_robin();
    test_clear();
    test_invalid_clear();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
